multicycle_controller: RTL and testbench

Moore-FSM control unit for the multicycle CPU. It replaces the single-cycle opcode decoder with a sequenced fetch/decode/execute/writeback controller that drives the shared-ALU, single-memory datapath. Memory wait states and multiply latency are parameters. Illegal opcodes go to a sticky trap state. It instantiates the existing `ALU_decoder` (Funct, ALUOp → Shamt, ALUControl) unchanged.

---
 rtl/multicycle_controller.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/writeback
// for the shared-ALU, single-memory multicycle datapath.
// Optional feature macro: MC_MUL_EN (builds the MULEX multiply state; when
// undefined, opcode 011100 decodes as an R-type instruction).

// ALU_decoder: maps ALUOp/Funct to the ALU operation and shift-amount select.
module ALU_decoder (
    input  logic [5:0] Funct,
    input  logic [1:0] ALUOp,
    output logic       Shamt,
    output logic [5:0] ALUControl
);
    // 00 = add (address/PC math), 01 = subtract (compare), 10 = funct field
    always_comb begin
        ALUControl = 6'b100000;
        Shamt      = 1'b0;
        case (ALUOp)
            2'b01: ALUControl = 6'b100010;
            2'b10: begin
                ALUControl = Funct;
                Shamt      = (Funct == 6'b000000) || (Funct == 6'b000010) ||
                             (Funct == 6'b000011);
            end
            default: ;
        endcase
    end
endmodule

module multicycle_controller #(
    parameter int MEM_LAT    = 0,
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       Shamt,
    output logic [5:0] ALUControl,
    output logic       Busy,
    output logic       Illegal,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEX = 4'd6, S_ALUWB = 4'd7,
        S_BEQ = 4'd8, S_BNE = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP = 4'd12, S_MULEX = 4'd13, S_NOP = 4'd14, S_TRAP = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_MUL  = 6'b011100;
    localparam logic [5:0] OP_NOP  = 6'b111000;

    localparam logic [3:0] LAST_MEM = 4'(MEM_LAT);
    localparam logic [3:0] LAST_MUL = 4'(MUL_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic       w_mem_last, w_mul_last;
    logic       w_pcwrite, w_branch, w_branch2, w_irwrite, w_memwrite, w_regwrite;
    logic       w_iord, w_regdst, w_memtoreg, w_alusrca, w_busy;
    logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

    assign w_mem_last = (r_cnt == LAST_MEM);
    assign w_mul_last = (r_cnt == LAST_MUL);

    // State register plus shared wait counter; the counter resets to 0 on
    // any cycle that does not stay in a counted state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_FETCH:  if (w_mem_last) r_state <= S_DECODE; else r_cnt <= r_cnt + 4'd1;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RT:        r_state <= S_RTEX;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_BNE:       r_state <= S_BNE;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
`ifdef MC_MUL_EN
                        OP_MUL:       r_state <= S_MULEX;
`else
                        OP_MUL:       r_state <= S_RTEX;
`endif
                        OP_NOP:       r_state <= S_NOP;
                        default:      r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR: r_state <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (w_mem_last) r_state <= S_MEMWB; else r_cnt <= r_cnt + 4'd1;
                S_MEMWR:  if (w_mem_last) r_state <= S_FETCH; else r_cnt <= r_cnt + 4'd1;
                S_RTEX:   r_state <= S_ALUWB;
`ifdef MC_MUL_EN
                S_MULEX:  if (w_mul_last) r_state <= S_ALUWB; else r_cnt <= r_cnt + 4'd1;
`endif
                S_ADDIEX: r_state <= S_ADDIWB;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from state and counter
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_branch2  = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_iord     = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;
        w_busy     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = w_mem_last;
                w_pcwrite = w_mem_last;
                w_busy    = ~w_mem_last;
            end
            S_DECODE: w_alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_busy = ~w_mem_last;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_busy     = ~w_mem_last;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_RTEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            // unreachable when the multiplier is not built
            S_MULEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_busy    = ~w_mul_last;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_BEQ, S_BNE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = (r_state == S_BEQ);
                w_branch2 = (r_state == S_BNE);
            end
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset so an aborted write cannot leak past the
    // reset edge; selects already show FETCH values because state clears async.
    assign PCEn     = ~reset & (w_pcwrite | (w_branch & Zero) | (w_branch2 & ~Zero));
    assign IRWrite  = ~reset & w_irwrite;
    assign MemWrite = ~reset & w_memwrite;
    assign RegWrite = ~reset & w_regwrite;
    assign Busy     = ~reset & w_busy;
    assign IorD     = w_iord;
    assign RegDst   = w_regdst;
    assign MemtoReg = w_memtoreg;
    assign ALUSrcA  = w_alusrca;
    assign ALUSrcB  = w_alusrcb;
    assign PCSrc    = w_pcsrc;
    assign Illegal  = (r_state == S_TRAP);
    assign State    = r_state;

    ALU_decoder u_alu_dec (
        .Funct      (Funct),
        .ALUOp      (w_aluop),
        .Shamt      (Shamt),
        .ALUControl (ALUControl)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: three instances with MEM_LAT
// 0, 2 and 3 share stimulus; each scenario checks the relevant instance.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero;

    logic       PCEn [3], IorD [3], IRWrite [3], MemWrite [3], RegWrite [3];
    logic       RegDst [3], MemtoReg [3], ALUSrcA [3], Shamt [3], Busy [3], Illegal [3];
    logic [1:0] ALUSrcB [3], PCSrc [3];
    logic [5:0] ALUControl [3];
    logic [3:0] State [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_controller #(.MEM_LAT(g == 0 ? 0 : g + 1), .MUL_CYCLES(4)) u_dut (
            .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
            .PCEn(PCEn[g]), .IorD(IorD[g]), .IRWrite(IRWrite[g]), .MemWrite(MemWrite[g]),
            .RegWrite(RegWrite[g]), .RegDst(RegDst[g]), .MemtoReg(MemtoReg[g]),
            .ALUSrcA(ALUSrcA[g]), .ALUSrcB(ALUSrcB[g]), .PCSrc(PCSrc[g]),
            .Shamt(Shamt[g]), .ALUControl(ALUControl[g]), .Busy(Busy[g]),
            .Illegal(Illegal[g]), .State(State[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] en(input int g);
        return {PCEn[g], IRWrite[g], MemWrite[g], RegWrite[g]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // hold reset over two edges, release mid-cycle; sample point is FETCH cycle 0
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Op    = 6'b100011;
        Funct = 6'b000000;
        Zero  = 1'b0;

        // reset state on the MEM_LAT=2 instance (Busy would be 1 in FETCH otherwise)
        @(posedge clk);
        #2;
        chk("rst_state",   32'(State[1]), 0);
        chk("rst_busy",    32'(Busy[1]), 0);
        chk("rst_en",      32'(en(1)), 0);
        chk("rst_alusrcb", 32'(ALUSrcB[1]), 'b01);
        chk("rst_illegal", 32'(Illegal[1]), 0);

        // LW, MEM_LAT=0: 0,1,2,3,4,0
        do_reset();
        chk("lw_c0_state", 32'(State[0]), 0);
        chk("lw_c0_en",    32'(en(0)), 'b1100);
        tick();
        chk("lw_c1_state", 32'(State[0]), 1);
        chk("lw_c1_en",    32'(en(0)), 0);
        chk("lw_c1_srcb",  32'(ALUSrcB[0]), 'b11);
        tick();
        chk("lw_c2_state", 32'(State[0]), 2);
        chk("lw_c2_src",   32'({ALUSrcA[0], ALUSrcB[0]}), 'b110);
        chk("lw_c2_aluc",  32'(ALUControl[0]), 'h20);
        tick();
        chk("lw_c3_state", 32'(State[0]), 3);
        chk("lw_c3_iord",  32'(IorD[0]), 1);
        chk("lw_c3_en",    32'(en(0)), 0);
        tick();
        chk("lw_c4_state", 32'(State[0]), 4);
        chk("lw_c4_en",    32'(en(0)), 'b0001);
        chk("lw_c4_m2r",   32'(MemtoReg[0]), 1);
        tick();
        chk("lw_c5_state", 32'(State[0]), 0);
        chk("lw_c5_en",    32'(en(0)), 'b1100);

        // SW, MEM_LAT=2: FETCH x3, DECODE, MEMADR, MEMWR x3
        Op = 6'b101011;
        do_reset();
        chk("sw_c0", 32'({State[1], IRWrite[1], Busy[1]}), 'b0000_0_1);
        tick();
        chk("sw_c1", 32'({State[1], IRWrite[1], Busy[1]}), 'b0000_0_1);
        tick();
        chk("sw_c2", 32'({State[1], IRWrite[1], PCEn[1], Busy[1]}), 'b0000_1_1_0);
        tick();
        chk("sw_c3_state", 32'(State[1]), 1);
        tick();
        chk("sw_c4_state", 32'(State[1]), 2);
        tick();
        chk("sw_c5", 32'({State[1], IorD[1], MemWrite[1], Busy[1]}), 'b0101_111);
        Op = 6'b100011;  // must not affect an access already under way
        tick();
        chk("sw_c6", 32'({State[1], IorD[1], MemWrite[1], Busy[1]}), 'b0101_111);
        tick();
        chk("sw_c7", 32'({State[1], IorD[1], MemWrite[1], Busy[1]}), 'b0101_110);
        tick();
        chk("sw_c8", 32'({State[1], MemWrite[1]}), 'b0000_0);

        // BEQ / BNE
        Op = 6'b000100; Zero = 1'b1;
        do_reset(); tick(); tick();
        chk("beq_state", 32'(State[0]), 8);
        chk("beq_pcen_z1", 32'({PCEn[0], PCSrc[0]}), 'b1_01);
        chk("beq_aluc", 32'(ALUControl[0]), 'h22);
        Zero = 1'b0; #1;
        chk("beq_pcen_z0", 32'(PCEn[0]), 0);
        tick();
        chk("beq_next", 32'(State[0]), 0);
        Op = 6'b000101; Zero = 1'b1;
        do_reset(); tick(); tick();
        chk("bne_state", 32'(State[0]), 9);
        chk("bne_pcen_z1", 32'(PCEn[0]), 0);
        Zero = 1'b0; #1;
        chk("bne_pcen_z0", 32'(PCEn[0]), 1);

        // R-type srl
        Op = 6'b000000; Funct = 6'b000010;
        do_reset(); tick(); tick();
        chk("rt_state", 32'(State[0]), 6);
        chk("rt_alu", 32'({ALUSrcA[0], Shamt[0], ALUControl[0]}), 'b1_1_000010);
        tick();
        chk("rt_wb", 32'({State[0], RegWrite[0], RegDst[0]}), 'b0111_11);
        tick();
        chk("rt_next", 32'(State[0]), 0);

        // ADDI, J, NOP
        Op = 6'b001000;
        do_reset(); tick(); tick();
        chk("addi_ex", 32'({State[0], ALUSrcA[0], ALUSrcB[0]}), 'b1010_1_10);
        tick();
        chk("addi_wb", 32'({State[0], RegWrite[0], RegDst[0]}), 'b1011_10);
        Op = 6'b000010;
        do_reset(); tick(); tick();
        chk("j_state", 32'({State[0], PCEn[0], PCSrc[0]}), 'b1100_1_10);
        tick();
        chk("j_next", 32'(State[0]), 0);
        Op = 6'b111000;
        do_reset(); tick(); tick();
        chk("nop_state", 32'({State[0], en(0)}), 'b1110_0000);
        tick();
        chk("nop_next", 32'(State[0]), 0);

        // MUL opcode
        Op = 6'b011100; Funct = 6'b011000;
        do_reset(); tick(); tick();
`ifdef MC_MUL_EN
        for (int i = 0; i < 4; i++) begin
            chk("mul_state", 32'(State[0]), 13);
            chk("mul_busy", 32'(Busy[0]), (i < 3) ? 1 : 0);
            tick();
        end
        chk("mul_wb", 32'({State[0], RegWrite[0], RegDst[0]}), 'b0111_11);
`else
        chk("mul_as_rt", 32'({State[0], Busy[0]}), 'b0110_0);
        tick();
        chk("mul_as_rt_wb", 32'({State[0], RegWrite[0], RegDst[0]}), 'b0111_11);
`endif

        // illegal opcode -> sticky TRAP
        Op = 6'b111111;
        do_reset();
        chk("trap_c0", 32'(State[0]), 0);
        tick();
        chk("trap_c1", 32'(State[0]), 1);
        tick();
        chk("trap_c2", 32'({State[0], Illegal[0]}), 'b1111_1);
        Op = 6'b100011;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("trap_hold", 32'({State[0], Illegal[0], en(0)}), 'b1111_1_0000);
        end
        #1 reset = 1'b1;
        #1;
        chk("trap_rst", 32'({State[0], Illegal[0]}), 'b0000_0);

        // reset during second MEMWR cycle, MEM_LAT=3
        Op = 6'b101011;
        do_reset();
        repeat (7) tick();
        chk("abort_pre", 32'({State[2], MemWrite[2], Busy[2]}), 'b0101_1_1);
        reset = 1'b1;
        #1;
        chk("abort_rst", 32'({State[2], en(2)}), 'b0000_0000);
        do_reset();
        chk("abort_c0", 32'({State[2], IRWrite[2], Busy[2]}), 'b0000_0_1);
        tick();
        tick();
        chk("abort_c2", 32'({State[2], IRWrite[2]}), 'b0000_0);
        tick();
        chk("abort_c3", 32'({State[2], IRWrite[2], Busy[2]}), 'b0000_1_0);
        tick();
        chk("abort_c4", 32'(State[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
